// File: rtl/bp_load_sequencer.sv
// bp_load_sequencer: feeds tile load requests to the BP fill controller, ping-ponging
// between two bank pairs with release-based credits. Define BP_SEQ_ABORT_EN to add abort/aborted.
module bp_load_sequencer #(
  parameter int DDR_ADDR_LEN = 32,
  parameter int ADDR_LEN     = 16,
  parameter int SINGLE_LEN   = 24,
  parameter int TILE_LEN     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DDR_ADDR_LEN-1:0] cfg_ddr_base,
  input  logic [DDR_ADDR_LEN-1:0] cfg_tile_stride,
  input  logic [TILE_LEN-1:0]     cfg_tile_num,
  input  logic [SINGLE_LEN-1:0]   cfg_tile_bytes,
  input  logic [ADDR_LEN-1:0]     cfg_bp_st_addr,
  input  logic [SINGLE_LEN-1:0]   cfg_line_width,
  output logic                    fifo_conf,
  output logic [DDR_ADDR_LEN-1:0] fifo_ddr_st_addr,
  output logic [SINGLE_LEN-1:0]   fifo_data_ddr_byte,
  output logic [ADDR_LEN-1:0]     fifo_bp_st_addr,
  output logic [1:0]              fifo_bp_st_num,
  output logic [SINGLE_LEN-1:0]   fifo_line_width,
  input  logic                    fifo_idle,
  output logic                    tile_ready,
  output logic                    tile_bank,
  input  logic                    tile_release,
  output logic                    busy,
  output logic                    done,
  output logic                    release_err
`ifdef BP_SEQ_ABORT_EN
  ,
  input  logic                    abort,
  output logic                    aborted
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CREDIT,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    NEXT
  } state_e;

  state_e                  state_q,        state_d;
  logic [1:0]              free_pairs_q,   free_pairs_d;
  logic [TILE_LEN-1:0]     tile_cnt_q,     tile_cnt_d;
  logic [TILE_LEN-1:0]     tile_num_q,     tile_num_d;
  logic [DDR_ADDR_LEN-1:0] stride_q,       stride_d;
  logic [DDR_ADDR_LEN-1:0] addr_acc_q,     addr_acc_d;
  logic [SINGLE_LEN-1:0]   bytes_q,        bytes_d;
  logic [SINGLE_LEN-1:0]   line_width_q,   line_width_d;
  logic [ADDR_LEN-1:0]     bp_addr_q,      bp_addr_d;
  logic                    bank_q,         bank_d;
  logic                    fifo_conf_q,    fifo_conf_d;
  logic [DDR_ADDR_LEN-1:0] fifo_addr_q,    fifo_addr_d;
  logic [SINGLE_LEN-1:0]   fifo_bytes_q,   fifo_bytes_d;
  logic [SINGLE_LEN-1:0]   fifo_lw_q,      fifo_lw_d;
  logic [ADDR_LEN-1:0]     fifo_bp_addr_q, fifo_bp_addr_d;
  logic [1:0]              fifo_num_q,     fifo_num_d;
  logic                    tile_ready_q,   tile_ready_d;
  logic                    tile_bank_q,    tile_bank_d;
  logic                    done_q,         done_d;
  logic                    err_q,          err_d;
  logic                    rel_ok;
`ifdef BP_SEQ_ABORT_EN
  logic                    abort_pend_q,   abort_pend_d;
  logic                    aborted_q,      aborted_d;
`endif

  always_comb begin
    state_d        = state_q;
    tile_cnt_d     = tile_cnt_q;
    tile_num_d     = tile_num_q;
    stride_d       = stride_q;
    addr_acc_d     = addr_acc_q;
    bytes_d        = bytes_q;
    line_width_d   = line_width_q;
    bp_addr_d      = bp_addr_q;
    bank_d         = bank_q;
    fifo_conf_d    = 1'b0;
    fifo_addr_d    = fifo_addr_q;
    fifo_bytes_d   = fifo_bytes_q;
    fifo_lw_d      = fifo_lw_q;
    fifo_bp_addr_d = fifo_bp_addr_q;
    fifo_num_d     = fifo_num_q;
    tile_ready_d   = 1'b0;
    tile_bank_d    = tile_bank_q;
    done_d         = 1'b0;
`ifdef BP_SEQ_ABORT_EN
    abort_pend_d   = abort_pend_q;
    aborted_d      = 1'b0;
`endif

    // A release with both pairs already free is dropped and flagged.
    rel_ok = tile_release && (free_pairs_q != 2'd2);
    err_d  = err_q | (tile_release && (free_pairs_q == 2'd2));
    case ({state_q == ISSUE, rel_ok})
      2'b10:   free_pairs_d = free_pairs_q - 2'd1;
      2'b01:   free_pairs_d = free_pairs_q + 2'd1;
      default: free_pairs_d = free_pairs_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          tile_num_d   = cfg_tile_num;
          stride_d     = cfg_tile_stride;
          addr_acc_d   = cfg_ddr_base;
          bytes_d      = cfg_tile_bytes;
          line_width_d = cfg_line_width;
          bp_addr_d    = cfg_bp_st_addr;
          bank_d       = 1'b0;
          tile_cnt_d   = '0;
          free_pairs_d = 2'd2;
`ifdef BP_SEQ_ABORT_EN
          abort_pend_d = 1'b0;
`endif
          state_d      = (cfg_tile_num == '0) ? NEXT : WAIT_CREDIT;
        end
      end

      WAIT_CREDIT: begin
`ifdef BP_SEQ_ABORT_EN
        if (abort) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else
`endif
        if ((free_pairs_q != 2'd0) && fifo_idle) begin
          // Descriptor registers load here and hold until the next issue.
          state_d        = ISSUE;
          fifo_conf_d    = 1'b1;
          fifo_addr_d    = addr_acc_q;
          fifo_bytes_d   = bytes_q;
          fifo_lw_d      = line_width_q;
          fifo_bp_addr_d = bp_addr_q;
          fifo_num_d     = {bank_q, 1'b0};
          addr_acc_d     = addr_acc_q + stride_q;
          bank_d         = ~bank_q;
          tile_cnt_d     = tile_cnt_q + TILE_LEN'(1);
        end
      end

      ISSUE: begin
`ifdef BP_SEQ_ABORT_EN
        if (abort) abort_pend_d = 1'b1;
`endif
        state_d = WAIT_BUSY;
      end

      WAIT_BUSY: begin
`ifdef BP_SEQ_ABORT_EN
        if (abort) abort_pend_d = 1'b1;
`endif
        if (!fifo_idle) state_d = WAIT_DONE;
      end

      WAIT_DONE: begin
`ifdef BP_SEQ_ABORT_EN
        if (abort) abort_pend_d = 1'b1;
        if (fifo_idle && (abort_pend_q || abort)) begin
          state_d      = IDLE;
          done_d       = 1'b1;
          aborted_d    = 1'b1;
          abort_pend_d = 1'b0;
        end else
`endif
        if (fifo_idle) begin
          state_d      = NEXT;
          tile_ready_d = 1'b1;
          tile_bank_d  = fifo_num_q[1];
        end
      end

      NEXT: begin
`ifdef BP_SEQ_ABORT_EN
        if (abort) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else
`endif
        if (tile_cnt_q == tile_num_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = WAIT_CREDIT;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      free_pairs_q   <= 2'd2;
      tile_cnt_q     <= '0;
      tile_num_q     <= '0;
      stride_q       <= '0;
      addr_acc_q     <= '0;
      bytes_q        <= '0;
      line_width_q   <= '0;
      bp_addr_q      <= '0;
      bank_q         <= 1'b0;
      fifo_conf_q    <= 1'b0;
      fifo_addr_q    <= '0;
      fifo_bytes_q   <= '0;
      fifo_lw_q      <= '0;
      fifo_bp_addr_q <= '0;
      fifo_num_q     <= '0;
      tile_ready_q   <= 1'b0;
      tile_bank_q    <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
`ifdef BP_SEQ_ABORT_EN
      abort_pend_q   <= 1'b0;
      aborted_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      free_pairs_q   <= free_pairs_d;
      tile_cnt_q     <= tile_cnt_d;
      tile_num_q     <= tile_num_d;
      stride_q       <= stride_d;
      addr_acc_q     <= addr_acc_d;
      bytes_q        <= bytes_d;
      line_width_q   <= line_width_d;
      bp_addr_q      <= bp_addr_d;
      bank_q         <= bank_d;
      fifo_conf_q    <= fifo_conf_d;
      fifo_addr_q    <= fifo_addr_d;
      fifo_bytes_q   <= fifo_bytes_d;
      fifo_lw_q      <= fifo_lw_d;
      fifo_bp_addr_q <= fifo_bp_addr_d;
      fifo_num_q     <= fifo_num_d;
      tile_ready_q   <= tile_ready_d;
      tile_bank_q    <= tile_bank_d;
      done_q         <= done_d;
      err_q          <= err_d;
`ifdef BP_SEQ_ABORT_EN
      abort_pend_q   <= abort_pend_d;
      aborted_q      <= aborted_d;
`endif
    end
  end

  assign fifo_conf          = fifo_conf_q;
  assign fifo_ddr_st_addr   = fifo_addr_q;
  assign fifo_data_ddr_byte = fifo_bytes_q;
  assign fifo_bp_st_addr    = fifo_bp_addr_q;
  assign fifo_bp_st_num     = fifo_num_q;
  assign fifo_line_width    = fifo_lw_q;
  assign tile_ready         = tile_ready_q;
  assign tile_bank          = tile_bank_q;
  assign busy               = (state_q != IDLE);
  assign done               = done_q;
  assign release_err        = err_q;
`ifdef BP_SEQ_ABORT_EN
  assign aborted            = aborted_q;
`endif

endmodule

// File: tb/tb_bp_load_sequencer.sv
// Bench for bp_load_sequencer: transaction-level reference model plus emulated fill
// controller and consumer, randomized sequences and directed corner cases.
module tb_bp_load_sequencer;
  localparam int DA = 32;
  localparam int AL = 16;
  localparam int SL = 24;
  localparam int TL = 16;

  logic          clk = 1'b0;
  logic          rst, start, fifo_idle, tile_release;
  logic [DA-1:0] cfg_ddr_base, cfg_tile_stride;
  logic [TL-1:0] cfg_tile_num;
  logic [SL-1:0] cfg_tile_bytes, cfg_line_width;
  logic [AL-1:0] cfg_bp_st_addr;
  logic          fifo_conf, tile_ready, tile_bank, busy, done, release_err;
  logic [DA-1:0] fifo_ddr_st_addr;
  logic [SL-1:0] fifo_data_ddr_byte, fifo_line_width;
  logic [AL-1:0] fifo_bp_st_addr;
  logic [1:0]    fifo_bp_st_num;

  always #5 clk = ~clk;

  bp_load_sequencer #(.DDR_ADDR_LEN(DA), .ADDR_LEN(AL), .SINGLE_LEN(SL), .TILE_LEN(TL)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_ddr_base(cfg_ddr_base), .cfg_tile_stride(cfg_tile_stride), .cfg_tile_num(cfg_tile_num),
    .cfg_tile_bytes(cfg_tile_bytes), .cfg_bp_st_addr(cfg_bp_st_addr), .cfg_line_width(cfg_line_width),
    .fifo_conf(fifo_conf), .fifo_ddr_st_addr(fifo_ddr_st_addr), .fifo_data_ddr_byte(fifo_data_ddr_byte),
    .fifo_bp_st_addr(fifo_bp_st_addr), .fifo_bp_st_num(fifo_bp_st_num), .fifo_line_width(fifo_line_width),
    .fifo_idle(fifo_idle), .tile_ready(tile_ready), .tile_bank(tile_bank), .tile_release(tile_release),
    .busy(busy), .done(done), .release_err(release_err)
  );

  // ---------------- reference model ----------------
  logic          e_conf, e_ready, e_bank, e_busy, e_done, e_err;
  logic [DA-1:0] e_addr;
  logic [SL-1:0] e_bytes, e_lw;
  logic [AL-1:0] e_bpaddr;
  logic [1:0]    e_num;
  int            m_free, m_free_pre;
  bit            ab;
  logic [DA-1:0] s_base, s_stride;
  logic [SL-1:0] s_bytes, s_lw;
  logic [AL-1:0] s_bpaddr;
  int unsigned   s_num;

  task automatic m_clear_all();
    e_conf = 0; e_ready = 0; e_bank = 0; e_busy = 0; e_done = 0; e_err = 0;
    e_addr = '0; e_bytes = '0; e_lw = '0; e_bpaddr = '0; e_num = '0;
    m_free = 2; m_free_pre = 2;
  endtask

  // One clock edge of the model: credit bookkeeping and pulse expiry.
  task automatic tick();
    @(posedge clk);
    ab = 0;
    if (rst) begin m_clear_all(); ab = 1; return; end
    m_free_pre = m_free;
    if (tile_release && m_free == 2) e_err = 1;
    m_free = m_free - (e_conf ? 1 : 0) + ((tile_release && m_free != 2) ? 1 : 0);
    e_conf = 0; e_ready = 0; e_done = 0;
  endtask

  task automatic run_seq();
    if (s_num == 0) begin
      tick(); if (ab) return;
      e_done = 1; e_busy = 0;
      return;
    end
    for (int unsigned i = 0; i < s_num; i++) begin
      do begin tick(); if (ab) return; end while (!(m_free_pre > 0 && fifo_idle));
      e_conf = 1;
      e_addr = s_base + DA'(i) * s_stride;
      e_num = (i % 2 == 1) ? 2'd2 : 2'd0;
      e_bytes = s_bytes; e_lw = s_lw; e_bpaddr = s_bpaddr;
      tick(); if (ab) return;
      do begin tick(); if (ab) return; end while (fifo_idle);
      do begin tick(); if (ab) return; end while (!fifo_idle);
      e_ready = 1; e_bank = (i % 2 == 1);
      tick(); if (ab) return;
      if (i == s_num - 1) begin e_done = 1; e_busy = 0; end
    end
  endtask

  initial begin : model
    m_clear_all();
    forever begin
      tick();
      if (!ab && start) begin
        s_base = cfg_ddr_base; s_stride = cfg_tile_stride; s_num = cfg_tile_num;
        s_bytes = cfg_tile_bytes; s_lw = cfg_line_width; s_bpaddr = cfg_bp_st_addr;
        m_free = 2; e_busy = 1;
        run_seq();
      end
    end
  end

  // ---------------- checking and stimulus ----------------
  int total = 0, bad = 0;
  int cyc_no = 0, conf_cnt = 0, done_cnt = 0;
  int fe_wait = 0, fe_len = 0, fe_len_fix = 0, rel_delay = -1, rel_on_conf = 0;
  bit fe_act = 0, auto_rel = 1;
  int rel_q[$];
  logic [DA-1:0] conf_addrs[$];
  logic [1:0]    conf_nums[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    chk("fifo_conf", fifo_conf, e_conf);
    chk("fifo_ddr_st_addr", fifo_ddr_st_addr, e_addr);
    chk("fifo_data_ddr_byte", fifo_data_ddr_byte, e_bytes);
    chk("fifo_bp_st_addr", fifo_bp_st_addr, e_bpaddr);
    chk("fifo_bp_st_num", fifo_bp_st_num, e_num);
    chk("fifo_line_width", fifo_line_width, e_lw);
    chk("tile_ready", tile_ready, e_ready);
    chk("tile_bank", tile_bank, e_bank);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("release_err", release_err, e_err);
    chk("free_pairs", dut.free_pairs_q, m_free);
  endtask

  // Advance one clock: emulate fill controller and consumer, then check outputs.
  task automatic cyc();
    @(posedge clk); #1;
    cyc_no++;
    if (fifo_conf) begin
      fe_act = 1; fe_wait = $urandom_range(1, 3);
      fe_len = (fe_len_fix > 0) ? fe_len_fix : $urandom_range(1, 4);
    end
    if (fe_act) begin
      if (fe_wait > 0) fe_wait--;
      else if (fe_len > 0) begin fifo_idle = 0; fe_len--; end
      else begin fifo_idle = 1; fe_act = 0; end
    end
    tile_release = 0;
    if (tile_ready && auto_rel)
      rel_q.push_back(cyc_no + ((rel_delay >= 0) ? rel_delay : $urandom_range(0, 8)));
    if (fifo_conf) begin
      conf_cnt++;
      if (conf_cnt == rel_on_conf) tile_release = 1;
    end else if (rel_q.size() > 0 && rel_q[0] <= cyc_no) begin
      void'(rel_q.pop_front());
      tile_release = 1;
    end
    @(negedge clk);
    compare_cycle();
    if (fifo_conf) begin conf_addrs.push_back(fifo_ddr_st_addr); conf_nums.push_back(fifo_bp_st_num); end
    if (done) done_cnt++;
  endtask

  task automatic do_reset();
    rst = 1; start = 0; tile_release = 0;
    fe_act = 0; fifo_idle = 1; rel_q.delete();
    cyc(); cyc();
    rst = 0; conf_cnt = 0;
    conf_addrs.delete(); conf_nums.delete();
  endtask

  task automatic set_cfg(input logic [DA-1:0] b, input logic [DA-1:0] s, input int n);
    cfg_ddr_base = b; cfg_tile_stride = s; cfg_tile_num = TL'(n);
    cfg_tile_bytes = SL'($urandom); cfg_bp_st_addr = AL'($urandom); cfg_line_width = SL'($urandom);
  endtask

  task automatic pulse_start();
    start = 1; cyc(); start = 0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < limit) begin cyc(); n++; end
    chk(name, done_cnt != d0, 1);
  endtask

  initial begin
    int d0, n;
    rst = 1; start = 0; fifo_idle = 1; tile_release = 0;
    set_cfg('0, '0, 0);
    do_reset();
    chk("reset_free_pairs", dut.free_pairs_q, 2);
    chk("reset_busy", busy, 0);

    // three tiles, releases 5 cycles after each ready
    rel_delay = 5; d0 = done_cnt;
    set_cfg(32'h1000, 32'h240, 3);
    pulse_start();
    wait_done(400, "s1_done");
    repeat (8) cyc();
    chk("s1_conf_cnt", conf_cnt, 3);
    chk("s1_addr0", conf_addrs[0], 32'h1000);
    chk("s1_addr1", conf_addrs[1], 32'h1240);
    chk("s1_addr2", conf_addrs[2], 32'h1480);
    chk("s1_num0", conf_nums[0], 0);
    chk("s1_num1", conf_nums[1], 2);
    chk("s1_num2", conf_nums[2], 0);
    chk("s1_done_cnt", done_cnt - d0, 1);

    // four tiles, no releases: stalls after two
    do_reset(); auto_rel = 0; d0 = done_cnt;
    set_cfg(32'h0, 32'h100, 4);
    pulse_start();
    repeat (40) cyc();
    chk("s2_conf_stall", conf_cnt, 2);
    chk("s2_busy_held", busy, 1);
    tile_release = 1; cyc(); cyc(); cyc();
    tile_release = 1; cyc();
    wait_done(300, "s2_done");
    chk("s2_conf_all", conf_cnt, 4);
    chk("s2_done_cnt", done_cnt - d0, 1);
    auto_rel = 1;

    // zero tiles
    do_reset(); d0 = done_cnt;
    set_cfg(32'h500, 32'h10, 0);
    pulse_start();
    chk("s3_done_early", done, 0);
    cyc();
    chk("s3_done_2cyc", done, 1);
    chk("s3_no_conf", conf_cnt, 0);

    // release coinciding with the second issue
    do_reset(); auto_rel = 0; rel_on_conf = 2;
    set_cfg(32'h2000, 32'h80, 2);
    pulse_start();
    wait_done(300, "s4_done");
    chk("s4_free_after_coincide", dut.free_pairs_q, 1);
    tile_release = 1; cyc();
    chk("s4_free_full", dut.free_pairs_q, 2);
    chk("s4_err_clear", release_err, 0);
    tile_release = 1; cyc();
    chk("s4_err_set", release_err, 1);
    repeat (3) cyc();
    chk("s4_err_sticky", release_err, 1);
    rel_on_conf = 0; auto_rel = 1; rel_delay = -1;

    // address wrap
    do_reset();
    set_cfg(32'hFFFFFF00, 32'h200, 2);
    pulse_start();
    wait_done(300, "s5_done");
    chk("s5_addr0", conf_addrs[0], 32'hFFFFFF00);
    chk("s5_addr1_wrap", conf_addrs[1], 32'h00000100);

    // reset while waiting for the fill to finish
    do_reset(); fe_len_fix = 8;
    set_cfg(32'h40, 32'h10, 2);
    pulse_start();
    n = 0;
    while (fifo_idle && n < 50) begin cyc(); n++; end
    chk("s6_fill_started", fifo_idle, 0);
    cyc();
    d0 = done_cnt; rst = 1; cyc();
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_addr", fifo_ddr_st_addr, 0);
    rst = 0; fe_act = 0; fifo_idle = 1; fe_len_fix = 0; rel_q.delete();
    cyc(); cyc();
    chk("s6_no_done", done_cnt - d0, 0);
    conf_cnt = 0;
    set_cfg(32'h3000, 32'h40, 3);
    pulse_start();
    wait_done(400, "s6_rerun_done");
    chk("s6_rerun_conf", conf_cnt, 3);

    // randomized sequences with config churn and ignored starts
    do_reset();
    for (int unsigned it = 0; it < 25; it++) begin
      set_cfg($urandom, $urandom, $urandom_range(0, 5));
      pulse_start();
      d0 = done_cnt; n = 0;
      while (done_cnt == d0 && n < 500) begin
        if ($urandom_range(0, 7) == 0) set_cfg($urandom, $urandom, $urandom_range(0, 5));
        if ($urandom_range(0, 11) == 0) start = 1;
        cyc(); start = 0; n++;
      end
      chk("rand_done", done_cnt != d0, 1);
      repeat ($urandom_range(0, 12)) cyc();
    end
    n = 0;
    while (busy && n < 500) begin cyc(); n++; end
    chk("rand_drain", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
